dcache_tid_allocator: RTL and testbench
=======================================

Name: dcache_tid_allocator

Overview:
- Hands out memory transaction IDs (TIDs) to the data cache miss/write paths and reclaims them when the memory response returns.
- Sizing comes from the derived core configuration: `MEM_TID_WIDTH` and `DCACHE_MAX_TX = 2**MEM_TID_WIDTH`.
- Sits between the dcache request arbiter (upstream) and the memory/NoC adapter (downstream).
- Provides free-list tracking, an in-flight limit, a drain/quiesce handshake and illegal-release detection.

Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_t` default `cva6_config_pkg::cva6_cfg`, derived core configuration. Uses `MEM_TID_WIDTH` (TW) and `DCACHE_MAX_TX` (N).
- `MaxInflight`, default `CVA6Cfg.DCACHE_MAX_TX`, cap on simultaneously allocated TIDs. Legal range 1..N.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `alloc_valid_o`  out  1  a TID is offered
- `alloc_tid_o`  out  TW  offered TID
- `alloc_ready_i`  in  1  consumer takes offered TID this cycle
- `release_valid_i`  in  1  response returned, free TID
- `release_tid_i`  in  TW  TID being freed
- `drain_req_i`  in  1  pulse: stop allocating, wait for all TIDs to return
- `drain_done_o`  out  1  one-cycle pulse when drain completes
- `busy_vec_o`  out  N  per-TID allocated flags
- `inflight_cnt_o`  out  TW+1  number of allocated TIDs
- `err_release_o`  out  1  sticky flag: release of a non-allocated TID seen

Behaviour:
- Reset (async assert, sync deassert as clocked):
  - `busy_vec_o` = 0, `inflight_cnt_o` = 0, `err_release_o` = 0, `drain_done_o` = 0.
  - FSM = RUN.
  - `alloc_valid_o` = 1 in the first cycle after reset, with `alloc_tid_o` = 0.
  - Reset mid-operation discards all outstanding state; late releases after reset set `err_release_o`.
- Offer (combinational from registers):
  - `alloc_tid_o` = lowest-index clear bit of `busy_vec`.
  - `alloc_valid_o` = (FSM==RUN) && (`inflight_cnt` < `MaxInflight`) && (some bit clear).
  - When `alloc_valid_o`=0, `alloc_tid_o` = 0.
- Allocate: `alloc_valid_o` && `alloc_ready_i` sets `busy[alloc_tid_o]` at the next edge. `alloc_ready_i` without valid has no effect.
- Release:
  - `release_valid_i` with `busy[release_tid_i]`=1 clears that bit at the next edge.
  - If the bit is already 0: no state change and `err_release_o` is set (sticky until reset).
- Simultaneous alloc and release in the same cycle:
  - Both take effect and the count is unchanged.
  - A TID released in cycle t is offerable no earlier than cycle t+1 (no same-cycle bypass).
- `inflight_cnt_o` = popcount of `busy_vec`, kept as a registered counter: +1 on alloc, −1 on legal release, ±0 when both occur. It never exceeds `MaxInflight`.
- FSM:
  - RUN -> DRAIN on `drain_req_i`. If `inflight_cnt` is already 0, the block still passes through DRAIN for one cycle.
  - DRAIN: `alloc_valid_o`=0; releases are accepted. DRAIN -> DONE when `inflight_cnt`==0, counting a release in the current cycle as taking effect.
  - DONE: `drain_done_o`=1 for exactly one cycle, `alloc_valid_o`=0; then -> RUN.
  - `drain_req_i` in DRAIN or DONE is ignored.
  - An allocation handshake in the same cycle as `drain_req_i` (while in RUN) is honoured; that TID must return before `drain_done_o`.
- Latency: allocate or release is visible on `busy_vec_o` and `inflight_cnt_o` one cycle after the handshake.
- Width rule: the counter is TW+1 bits, so it holds N exactly (N=4 gives a 3-bit counter, max value 4).

Test Plan (`MemTidWidth`=2, N=4 unless stated):
- Reset, hold `alloc_ready_i`=1 for 5 cycles -> TIDs 0,1,2,3 granted on cycles 1–4; cycle 5 `alloc_valid_o`=0; `inflight_cnt_o`=4; `busy_vec_o`=4'b1111.
- All busy, release TID 2 at cycle t -> `alloc_valid_o`=1 with `alloc_tid_o`=2 at t+1, not at t.
- Busy=4'b0011, alloc (offers 2) and release TID 0 in the same cycle -> next `busy_vec_o`=4'b0110, `inflight_cnt_o` stays 2; next offer is TID 0.
- `MaxInflight`=2: continuous ready -> only TIDs 0,1 granted; release 1 -> TID 1 re-offered; count never exceeds 2.
- Busy=4'b0101, `drain_req_i` pulse -> `alloc_valid_o`=0 immediately; release 0 then 2 -> `drain_done_o` high exactly 1 cycle after the cycle TID 2 is released; then RUN with TID 0 offered. Also: drain with 0 in flight -> `drain_done_o` 2 cycles after the request.
- Release TID 3 while `busy_vec_o`=4'b0001 -> `busy_vec_o` unchanged, `err_release_o`=1 and it stays 1; assert `rst_ni` low mid-traffic -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dcache_tid_allocator.sv
// Memory transaction ID allocator: offers the lowest free TID, caps in-flight count, drains on request.
// Offer is combinational from registers; alloc/release show on busy/count one cycle after the handshake.
module dcache_tid_allocator #(
  parameter int unsigned MemTidWidth = 2,
  parameter int unsigned DcacheMaxTx = 2 ** MemTidWidth,
  parameter int unsigned MaxInflight = DcacheMaxTx
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   alloc_valid_o,
  output logic [MemTidWidth-1:0] alloc_tid_o,
  input  logic                   alloc_ready_i,
  input  logic                   release_valid_i,
  input  logic [MemTidWidth-1:0] release_tid_i,
  input  logic                   drain_req_i,
  output logic                   drain_done_o,
  output logic [DcacheMaxTx-1:0] busy_vec_o,
  output logic [MemTidWidth:0]   inflight_cnt_o,
  output logic                   err_release_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  localparam logic [MemTidWidth:0] CntMax = (MemTidWidth+1)'(MaxInflight);

  state_e                 state_q, state_d;
  logic [DcacheMaxTx-1:0] busy_q, busy_d;
  logic [MemTidWidth:0]   cnt_q, cnt_d;
  logic                   err_q;
  logic [MemTidWidth-1:0] free_tid;
  logic                   has_free;
  logic                   offer;
  logic                   alloc_fire;
  logic                   rel_legal;
  logic                   rel_illegal;

  // Scan from the top so the last hit wins: lowest clear index.
  always_comb begin
    free_tid = '0;
    for (int i = DcacheMaxTx - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_tid = MemTidWidth'(i);
    end
  end

  assign has_free    = ~&busy_q;
  assign offer       = (state_q == RUN) && (cnt_q < CntMax) && has_free;
  assign alloc_fire  = offer && alloc_ready_i;
  assign rel_legal   = release_valid_i && busy_q[release_tid_i];
  assign rel_illegal = release_valid_i && !busy_q[release_tid_i];

  // Alloc only targets a clear bit and release only a set bit, so they never collide.
  always_comb begin
    busy_d = busy_q;
    if (alloc_fire) busy_d[free_tid] = 1'b1;
    if (rel_legal)  busy_d[release_tid_i] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({alloc_fire, rel_legal})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // DRAIN looks at the post-release count so a final release completes the drain that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req_i) state_d = DRAIN;
      DRAIN:   if (cnt_d == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      busy_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      if (rel_illegal) err_q <= 1'b1;
    end
  end

  assign alloc_valid_o  = offer;
  assign alloc_tid_o    = offer ? free_tid : '0;
  assign drain_done_o   = (state_q == DONE);
  assign busy_vec_o     = busy_q;
  assign inflight_cnt_o = cnt_q;
  assign err_release_o  = err_q;

endmodule

// File: tb/tb_dcache_tid_allocator.sv
// Bench for dcache_tid_allocator: directed vector table, in-flight cap sequence, async reset, random traffic vs model.
module tb_dcache_tid_allocator;

  localparam int TW = 2;
  localparam int N  = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic clk;
  logic rst_n;

  logic          ready, rv, drain;
  logic [TW-1:0] rtid;
  logic          a_valid, done, err;
  logic [TW-1:0] a_tid;
  logic [N-1:0]  busy;
  logic [TW:0]   cnt;

  logic          l_ready, l_rv, l_drain;
  logic [TW-1:0] l_rtid;
  logic          l_valid, l_done, l_err;
  logic [TW-1:0] l_tid;
  logic [N-1:0]  l_busy;
  logic [TW:0]   l_cnt;

  dcache_tid_allocator #(.MemTidWidth(TW), .MaxInflight(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_valid_o(a_valid), .alloc_tid_o(a_tid), .alloc_ready_i(ready),
    .release_valid_i(rv), .release_tid_i(rtid),
    .drain_req_i(drain), .drain_done_o(done),
    .busy_vec_o(busy), .inflight_cnt_o(cnt), .err_release_o(err)
  );

  dcache_tid_allocator #(.MemTidWidth(TW), .MaxInflight(2)) u_lim (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_valid_o(l_valid), .alloc_tid_o(l_tid), .alloc_ready_i(l_ready),
    .release_valid_i(l_rv), .release_tid_i(l_rtid),
    .drain_req_i(l_drain), .drain_done_o(l_done),
    .busy_vec_o(l_busy), .inflight_cnt_o(l_cnt), .err_release_o(l_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: a set of busy TIDs, a mode, a sticky error flag.
  bit m_busy[N];
  int m_mode;
  bit m_err;

  typedef struct {
    bit          rdy;
    bit          rv;
    int          rtid;
    bit          drn;
    bit          ev;
    int          etid;
    logic [N-1:0] ebusy;
    int          ecnt;
    bit          edone;
    bit          eerr;
  } vec_t;

  function automatic vec_t mk(bit rdy, bit v, int t, bit d, bit ev, int et,
                              logic [N-1:0] eb, int ec, bit ed, bit ee);
    vec_t r;
    r.rdy = rdy; r.rv = v; r.rtid = t; r.drn = d;
    r.ev = ev; r.etid = et; r.ebusy = eb; r.ecnt = ec; r.edone = ed; r.eerr = ee;
    return r;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int m_offer();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_mode = M_RUN;
    m_err  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle on the main DUT: drive, check at negedge, advance model at posedge.
  task automatic cyc(input vec_t v, input bit use_tab);
    bit ev;
    int et;
    bit legal;
    ready = v.rdy; rv = v.rv; rtid = v.rtid[TW-1:0]; drain = v.drn;
    ev = (m_mode == M_RUN) && (m_count() < 4) && (m_offer() >= 0);
    et = ev ? m_offer() : 0;
    @(negedge clk);
    chk("valid", a_valid, ev);
    chk("tid",   a_tid,   et);
    chk("busy",  busy,    m_vec());
    chk("cnt",   cnt,     m_count());
    chk("err",   err,     m_err);
    chk("done",  done,    m_mode == M_DONE);
    if (use_tab) begin
      chk("tab_valid", a_valid, v.ev);
      chk("tab_tid",   a_tid,   v.etid);
      chk("tab_busy",  busy,    v.ebusy);
      chk("tab_cnt",   cnt,     v.ecnt);
      chk("tab_done",  done,    v.edone);
      chk("tab_err",   err,     v.eerr);
    end
    @(posedge clk);
    legal = v.rv && m_busy[v.rtid];
    if (v.rv && !m_busy[v.rtid]) m_err = 1'b1;
    if (ev && v.rdy) m_busy[et] = 1'b1;
    if (legal) m_busy[v.rtid] = 1'b0;
    case (m_mode)
      M_RUN:   if (v.drn) m_mode = M_DRAIN;
      M_DRAIN: if (m_count() == 0) m_mode = M_DONE;
      default: m_mode = M_RUN;
    endcase
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  busy,    0);
    chk("rst_cnt",   cnt,     0);
    chk("rst_err",   err,     0);
    chk("rst_done",  done,    0);
    chk("rst_valid", a_valid, 1);
    chk("rst_tid",   a_tid,   0);
    model_reset();
    ready = 0; rv = 0; drain = 0; rtid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tab[21];
  bit   lr[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
  bit   lv[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
  int   lt[8] = '{0, 1, 0, 0, 0, 1, 1, 0};
  int   lc[8] = '{0, 1, 2, 2, 2, 1, 1, 2};

  initial begin
    //             rdy rv t  drn  ev tid busy     cnt done err
    tab[0]  = mk(1, 0, 0, 0,  1, 0, 4'b0000, 0, 0, 0);
    tab[1]  = mk(1, 0, 0, 0,  1, 1, 4'b0001, 1, 0, 0);
    tab[2]  = mk(1, 0, 0, 0,  1, 2, 4'b0011, 2, 0, 0);
    tab[3]  = mk(1, 0, 0, 0,  1, 3, 4'b0111, 3, 0, 0);
    tab[4]  = mk(1, 0, 0, 0,  0, 0, 4'b1111, 4, 0, 0);
    tab[5]  = mk(0, 1, 2, 0,  0, 0, 4'b1111, 4, 0, 0);
    tab[6]  = mk(0, 1, 3, 0,  1, 2, 4'b1011, 3, 0, 0);
    tab[7]  = mk(1, 1, 0, 0,  1, 2, 4'b0011, 2, 0, 0);
    tab[8]  = mk(0, 1, 1, 0,  1, 0, 4'b0110, 2, 0, 0);
    tab[9]  = mk(1, 0, 0, 0,  1, 0, 4'b0100, 1, 0, 0);
    tab[10] = mk(0, 0, 0, 1,  1, 1, 4'b0101, 2, 0, 0);
    tab[11] = mk(0, 1, 0, 0,  0, 0, 4'b0101, 2, 0, 0);
    tab[12] = mk(0, 1, 2, 0,  0, 0, 4'b0100, 1, 0, 0);
    tab[13] = mk(0, 0, 0, 0,  0, 0, 4'b0000, 0, 1, 0);
    tab[14] = mk(0, 0, 0, 1,  1, 0, 4'b0000, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 1,  0, 0, 4'b0000, 0, 0, 0);
    tab[16] = mk(0, 0, 0, 0,  0, 0, 4'b0000, 0, 1, 0);
    tab[17] = mk(1, 0, 0, 0,  1, 0, 4'b0000, 0, 0, 0);
    tab[18] = mk(0, 1, 3, 0,  1, 1, 4'b0001, 1, 0, 0);
    tab[19] = mk(0, 0, 0, 0,  1, 1, 4'b0001, 1, 0, 1);
    tab[20] = mk(0, 0, 0, 0,  1, 1, 4'b0001, 1, 0, 1);

    rst_n = 1'b0;
    ready = 0; rv = 0; rtid = '0; drain = 0;
    l_ready = 0; l_rv = 0; l_rtid = '0; l_drain = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) cyc(tab[k], 1'b1);

    // In-flight cap of 2 on the second instance; main DUT sits idle.
    for (int k = 0; k < 8; k++) begin
      l_ready = lr[k];
      l_rv    = (k == 4);
      l_rtid  = 2'd1;
      @(negedge clk);
      chk("lim_valid", l_valid, lv[k]);
      chk("lim_tid",   l_tid,   lt[k]);
      chk("lim_cnt",   l_cnt,   lc[k]);
      @(posedge clk);
      #1;
    end
    l_ready = 0; l_rv = 0;
    chk("lim_busy", l_busy, 4'b0011);

    // Reset mid-operation, then a late release of a TID allocated before reset.
    async_reset();
    chk("lim_rst_busy", l_busy, 0);
    cyc(mk(0, 1, 0, 0, 1, 0, 4'b0000, 0, 0, 0), 1'b1);
    cyc(mk(0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 1), 1'b1);
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      int   t;
      if (i == 1500) async_reset();
      t = int'($urandom_range(0, N - 1));
      if (($urandom % 8) != 0) begin
        for (int j = 0; j < N; j++) begin
          if (m_busy[(t + j) % N]) begin
            t = (t + j) % N;
            break;
          end
        end
      end
      v = mk(bit'($urandom % 2), bit'($urandom % 2), t, ($urandom % 40) == 0,
             0, 0, '0, 0, 0, 0);
      cyc(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
